kmap_sweep_checker: RTL and testbench

//  Drives an exhaustive input sweep into a combinational K-map function block and checks its response.

---
 rtl/kmap_pkg.sv | 16 +
 rtl/kmap_sweep_checker_if.sv | 48 ++++
 rtl/kmap_settle_timer.sv | 28 ++
 rtl/kmap_sweep_checker.sv | 128 ++++++++++++
 tb/tb_kmap_sweep_checker.sv | 189 ++++++++++++++++++
 5 files changed

// File: rtl/kmap_pkg.sv
// Shared types and helpers for the K-map sweep checker and its benches.
package kmap_pkg;

    typedef logic [1:0] state_t;

    localparam state_t S_IDLE   = 2'd0;
    localparam state_t S_DRIVE  = 2'd1;
    localparam state_t S_SAMPLE = 2'd2;
    localparam state_t S_FIN    = 2'd3;

    // Number of vectors for an n-input function.
    function automatic int unsigned nv(input int unsigned n);
        return 32'd1 << n;
    endfunction

endpackage

// File: rtl/kmap_sweep_checker_if.sv
// Bundle between the sweep checker and the K-map block under test.
interface kmap_sweep_checker_if
    import kmap_pkg::*;
#(
    parameter int N_IN = 5
);

    logic                   start;
    logic                   f_in;
    logic [N_IN-1:0]        vec;
    logic                   vec_valid;
    logic                   busy;
    logic                   done;
    logic                   pass;
    logic [N_IN:0]          err_count;
    logic                   first_err_vld;
    logic [N_IN-1:0]        first_err_idx;
    logic [nv(N_IN)-1:0]    tt_obs;

    modport master (
        input  start,
        input  f_in,
        output vec,
        output vec_valid,
        output busy,
        output done,
        output pass,
        output err_count,
        output first_err_vld,
        output first_err_idx,
        output tt_obs
    );

    modport slave (
        output start,
        output f_in,
        input  vec,
        input  vec_valid,
        input  busy,
        input  done,
        input  pass,
        input  err_count,
        input  first_err_vld,
        input  first_err_idx,
        input  tt_obs
    );

endinterface

// File: rtl/kmap_settle_timer.sv
// Counts the cycles a vector is held before the function output is sampled.
module kmap_settle_timer #(
    parameter int SETTLE = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    logic [W-1:0] cnt;

    assign expired = en && (cnt == W'(SETTLE - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= expired ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/kmap_sweep_checker.sv
// Exhaustive input sweep of a combinational K-map block with truth-table check.
module kmap_sweep_checker
    import kmap_pkg::*;
#(
    parameter int                  N_IN   = 5,
    parameter int                  SETTLE = 2,
    parameter logic [nv(N_IN)-1:0] EXP_TT = '0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    kmap_sweep_checker_if.master bus
);

    localparam int            NVEC    = nv(N_IN);
    localparam logic [N_IN:0] ERR_MAX = (N_IN + 1)'(NVEC);

    state_t              state;
    state_t              state_nxt;
    logic [N_IN-1:0]     idx;
    logic                expired;
    logic                in_drive;
    logic                in_sample;
    logic                last;
    logic                miss;
    logic [N_IN:0]       err_nxt;

    logic [N_IN-1:0]     vec;
    logic                vec_valid;
    logic                busy;
    logic                done;
    logic                pass;
    logic [N_IN:0]       err_count;
    logic                first_err_vld;
    logic [N_IN-1:0]     first_err_idx;
    logic [NVEC-1:0]     tt_obs;

    assign in_drive  = (state == S_DRIVE);
    assign in_sample = (state == S_SAMPLE);
    assign last      = (idx == '1);
    assign miss      = in_sample && (bus.f_in != EXP_TT[idx]);

    // Saturating so the count can reach 2^N_IN without wrapping.
    always_comb begin
        err_nxt = err_count;
        if (miss && (err_count != ERR_MAX)) begin
            err_nxt = err_count + 1'b1;
        end
    end

    kmap_settle_timer #(
        .SETTLE (SETTLE)
    ) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (!in_drive),
        .en      (in_drive),
        .expired (expired)
    );

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE:   if (bus.start) state_nxt = S_DRIVE;
            S_DRIVE:  if (expired) state_nxt = S_SAMPLE;
            S_SAMPLE: state_nxt = last ? S_FIN : S_DRIVE;
            S_FIN:    state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_IDLE;
            idx           <= '0;
            vec           <= '0;
            vec_valid     <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            pass          <= 1'b0;
            err_count     <= '0;
            first_err_vld <= 1'b0;
            first_err_idx <= '0;
            tt_obs        <= '0;
        end else begin
            state     <= state_nxt;
            vec_valid <= (state_nxt == S_DRIVE) ||
                         (state_nxt == S_SAMPLE);
            busy      <= (state_nxt != S_IDLE);
            done      <= (state_nxt == S_FIN);
            if ((state == S_IDLE) && bus.start) begin
                idx           <= '0;
                vec           <= '0;
                pass          <= 1'b0;
                err_count     <= '0;
                first_err_vld <= 1'b0;
                first_err_idx <= '0;
                tt_obs        <= '0;
            end
            if (in_sample) begin
                tt_obs[idx] <= bus.f_in;
                err_count   <= err_nxt;
                if (miss && !first_err_vld) begin
                    first_err_vld <= 1'b1;
                    first_err_idx <= idx;
                end
                // Verdict includes the last vector's compare.
                if (last) begin
                    pass <= (err_nxt == '0);
                    vec  <= '0;
                end else begin
                    idx <= idx + 1'b1;
                    vec <= idx + 1'b1;
                end
            end
        end
    end

    assign bus.vec           = vec;
    assign bus.vec_valid     = vec_valid;
    assign bus.busy          = busy;
    assign bus.done          = done;
    assign bus.pass          = pass;
    assign bus.err_count     = err_count;
    assign bus.first_err_vld = first_err_vld;
    assign bus.first_err_idx = first_err_idx;
    assign bus.tt_obs        = tt_obs;

endmodule

// File: tb/tb_kmap_sweep_checker.sv
// Directed bench: checker sweeping a 4-input and a 5-input K-map model.
module tb_kmap_sweep_checker;

    function automatic logic k1(input logic [3:0] v);
        logic a, b, c, d;
        {a, b, c, d} = v;
        return (~b & c) | (~a & b & d) | (a & ~c & ~d);
    endfunction

    function automatic logic k2(input logic [4:0] v);
        return (v[4] & v[3]) | (~v[2] & v[1] & v[0]) |
               ((v[4] ^ v[0]) & ~v[1]);
    endfunction

    function automatic logic [31:0] k2_tt();
        logic [31:0] t;
        t = '0;
        for (int i = 0; i < 32; i++) t[i] = k2(5'(i));
        return t;
    endfunction

    localparam logic [31:0] K2_TT = k2_tt();

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic force0 = 1'b0;
    logic start_ab = 1'b0;
    logic start_c = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    kmap_sweep_checker_if #(.N_IN(4)) ia ();
    kmap_sweep_checker_if #(.N_IN(4)) ib ();
    kmap_sweep_checker_if #(.N_IN(5)) ic ();

    assign ia.start = start_ab;
    assign ib.start = start_ab;
    assign ic.start = start_c;
    assign ia.f_in  = force0 ? 1'b0 : k1(ia.vec);
    assign ib.f_in  = k1(ib.vec);
    assign ic.f_in  = k2(ic.vec);

    kmap_sweep_checker #(
        .N_IN(4), .SETTLE(2), .EXP_TT(16'h1DAC)
    ) dut_a (.clk(clk), .rst_n(rst_n), .bus(ia));

    kmap_sweep_checker #(
        .N_IN(4), .SETTLE(2), .EXP_TT(16'h1DAD)
    ) dut_b (.clk(clk), .rst_n(rst_n), .bus(ib));

    kmap_sweep_checker #(
        .N_IN(5), .SETTLE(2), .EXP_TT(K2_TT)
    ) dut_c (.clk(clk), .rst_n(rst_n), .bus(ic));

    task automatic chk(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Sweep on dut_a/dut_b; optional stray starts at cycles 5 and 30.
    task automatic sweep_ab(input bit inject,
                            output int lat,
                            output int ndone,
                            output int vbad);
        lat = -1;
        ndone = 0;
        vbad = 0;
        @(negedge clk);
        start_ab = 1'b1;
        @(negedge clk);
        for (int n = 1; n <= 80; n++) begin
            start_ab = inject && (n == 5 || n == 30);
            if (ia.done) begin
                ndone++;
                if (lat < 0) lat = n;
            end
            if (n <= 48) begin
                if (!ia.vec_valid || ia.vec != 4'((n - 1) / 3))
                    vbad++;
            end else if (ia.vec_valid || ia.vec != 4'd0) begin
                vbad++;
            end
            @(negedge clk);
        end
        start_ab = 1'b0;
    endtask

    int lat, nd, vb;

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_vec", ia.vec, 0);
        chk("rst_vvalid", ia.vec_valid, 0);
        chk("rst_busy", ia.busy, 0);
        chk("rst_done", ia.done, 0);
        chk("rst_pass", ia.pass, 0);
        chk("rst_err", ia.err_count, 0);
        chk("rst_tt", ia.tt_obs, 0);
        rst_n = 1'b1;

        sweep_ab(1'b0, lat, nd, vb);
        chk("t1_lat", 64'(lat), 49);
        chk("t1_ndone", 64'(nd), 1);
        chk("t1_vec", 64'(vb), 0);
        chk("t1_pass", ia.pass, 1);
        chk("t1_err", ia.err_count, 0);
        chk("t1_fev", ia.first_err_vld, 0);
        chk("t1_tt", ia.tt_obs, 16'h1DAC);
        chk("t1_busy", ia.busy, 0);
        chk("t2_pass", ib.pass, 0);
        chk("t2_err", ib.err_count, 1);
        chk("t2_fev", ib.first_err_vld, 1);
        chk("t2_fei", ib.first_err_idx, 0);
        chk("t2_tt", ib.tt_obs, 16'h1DAC);

        force0 = 1'b1;
        sweep_ab(1'b0, lat, nd, vb);
        force0 = 1'b0;
        chk("t3_lat", 64'(lat), 49);
        chk("t3_err", ia.err_count, 8);
        chk("t3_fev", ia.first_err_vld, 1);
        chk("t3_fei", ia.first_err_idx, 2);
        chk("t3_pass", ia.pass, 0);
        chk("t3_tt", ia.tt_obs, 0);

        sweep_ab(1'b1, lat, nd, vb);
        chk("t4_lat", 64'(lat), 49);
        chk("t4_ndone", 64'(nd), 1);
        chk("t4_vec", 64'(vb), 0);
        chk("t4_pass", ia.pass, 1);
        chk("t4_err", ia.err_count, 0);

        @(negedge clk);
        start_ab = 1'b1;
        @(negedge clk);
        start_ab = 1'b0;
        for (int n = 0; n < 60 && ia.vec != 4'd7; n++)
            @(negedge clk);
        chk("t5_reach7", ia.vec, 7);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_vec", ia.vec, 0);
        chk("t5_vvalid", ia.vec_valid, 0);
        chk("t5_busy", ia.busy, 0);
        chk("t5_tt", ia.tt_obs, 0);
        chk("t5_errb", ib.err_count, 0);
        chk("t5_fevb", ib.first_err_vld, 0);
        nd = 0;
        repeat (3) begin
            @(negedge clk);
            if (ia.done) nd++;
        end
        chk("t5_nodone", 64'(nd), 0);
        rst_n = 1'b1;
        sweep_ab(1'b0, lat, nd, vb);
        chk("t5_lat", 64'(lat), 49);
        chk("t5_vec_seq", 64'(vb), 0);
        chk("t5_pass", ia.pass, 1);
        chk("t5_tt", ia.tt_obs, 16'h1DAC);

        @(negedge clk);
        start_c = 1'b1;
        @(negedge clk);
        start_c = 1'b0;
        lat = -1;
        for (int n = 1; n <= 200; n++) begin
            if (ic.done) begin
                lat = n;
                break;
            end
            @(negedge clk);
        end
        chk("t6_lat", 64'(lat), 97);
        chk("t6_pass", ic.pass, 1);
        chk("t6_err", ic.err_count, 0);
        chk("t6_tt", ic.tt_obs, K2_TT);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
